// File: rtl/mcpu_soc_swdebounce_pkg.sv
// Shared constants and vector types for the switch/button debouncer.
// Channel counts and the counter width are common to the SoC. The debounce length is a module parameter.
package mcpu_soc_swdebounce_pkg;

    localparam int unsigned NUM_SW   = 10;
    localparam int unsigned NUM_BTN  = 4;
    localparam int unsigned NUM_CHAN = NUM_SW + NUM_BTN;
    localparam int unsigned CNT_W    = 16;

    typedef logic [NUM_SW-1:0]  sw_vec_t;
    typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/mcpu_soc_swdebounce_if.sv
// MMIO-facing bundle between the debouncer (master) and the LED/switch block (slave).
interface mcpu_soc_swdebounce_if;
    import mcpu_soc_swdebounce_pkg::*;

    sw_vec_t  ext_switches;
    btn_vec_t ext_buttons;
    btn_vec_t btn_press;
    logic     sw_change;
    btn_vec_t press_sticky;
    btn_vec_t press_clear;

    modport master (
        output ext_switches,
        output ext_buttons,
        output btn_press,
        output sw_change,
        output press_sticky,
        input  press_clear
    );

    modport slave (
        input  ext_switches,
        input  ext_buttons,
        input  btn_press,
        input  sw_change,
        input  press_sticky,
        output press_clear
    );

endinterface

// File: rtl/mcpu_soc_debounce_chan.sv
// One debounce channel: a two-flop synchronizer, a saturating mismatch counter and an accepted level.
// The accept output is high in the cycle whose closing edge loads the new level.
module mcpu_soc_debounce_chan
    import mcpu_soc_swdebounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    // Synchronizer stage boundary: din -> meta_p0 -> sync_p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= din;
            sync_p1 <= meta_p0;
        end
    end

    assign mismatch = sync_p1 ^ level;
    assign accept   = mismatch && (cnt == CNT_LAST);

    // Any return to the accepted level restarts the count, so short glitches never load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (!mismatch) begin
            cnt <= '0;
        end else if (accept) begin
            level <= sync_p1;
            cnt   <= '0;
        end else if (cnt < CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mcpu_soc_swdebounce.sv
// Debounces 10 board switches and 4 buttons and derives press pulses, a switch-change pulse and sticky press flags.
// Buttons are optionally inverted at the pin so every internal button bit reads 1 when pressed.
module mcpu_soc_swdebounce
    import mcpu_soc_swdebounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clkrst_core_clk,
    input  logic                  clkrst_core_rst_n,
    input  sw_vec_t               raw_switches,
    input  btn_vec_t              raw_buttons,
    mcpu_soc_swdebounce_if.master mmio
);

    btn_vec_t            btn_in;
    logic [NUM_CHAN-1:0] chan_in;
    logic [NUM_CHAN-1:0] chan_level;
    logic [NUM_CHAN-1:0] chan_accept;

    sw_vec_t             sw_level;
    sw_vec_t             sw_accept;
    btn_vec_t            btn_level;
    btn_vec_t            btn_accept;
    btn_vec_t            btn_rise;

    btn_vec_t            btn_press_q;
    logic                sw_change_q;
    btn_vec_t            sticky_q;

    assign btn_in  = BTN_ACTIVE_LOW ? ~raw_buttons : raw_buttons;
    assign chan_in = {btn_in, raw_switches};

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        mcpu_soc_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clkrst_core_clk),
            .rst_n  (clkrst_core_rst_n),
            .din    (chan_in[i]),
            .level  (chan_level[i]),
            .accept (chan_accept[i])
        );
    end

    assign sw_level   = chan_level[NUM_SW-1:0];
    assign sw_accept  = chan_accept[NUM_SW-1:0];
    assign btn_level  = chan_level[NUM_CHAN-1:NUM_SW];
    assign btn_accept = chan_accept[NUM_CHAN-1:NUM_SW];

    // An accepted change on a button currently at 0 is a press
    assign btn_rise = btn_accept & ~btn_level;

    // Event stage boundary: pulses land on the same edge as the level they report.
    // Sticky flags are also held by a live btn_press, so a clear in that cycle loses.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            btn_press_q <= '0;
            sw_change_q <= 1'b0;
            sticky_q    <= '0;
        end else begin
            btn_press_q <= btn_rise;
            sw_change_q <= |sw_accept;
            sticky_q    <= (sticky_q & ~mmio.press_clear) | btn_rise | btn_press_q;
        end
    end

    assign mmio.ext_switches = sw_level;
    assign mmio.ext_buttons  = btn_level;
    assign mmio.btn_press    = btn_press_q;
    assign mmio.sw_change    = sw_change_q;
    assign mmio.press_sticky = sticky_q;

endmodule

// File: tb/tb_mcpu_soc_swdebounce.sv
// Directed bench for the debouncer with DEBOUNCE_CYCLES=4 and active-low buttons.
module tb_mcpu_soc_swdebounce;
    import mcpu_soc_swdebounce_pkg::*;

    localparam int unsigned DC = 4;

    typedef struct {
        logic [9:0] sw;
        logic [3:0] btn;
        logic [3:0] clr;
        logic [9:0] e_sw;
        logic [3:0] e_btn;
        logic [3:0] e_press;
        logic       e_chg;
        logic [3:0] e_sticky;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    sw_vec_t  raw_switches = '0;
    btn_vec_t raw_buttons = 4'hF;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t tbl[$];

    mcpu_soc_swdebounce_if mmio();

    mcpu_soc_swdebounce #(
        .DEBOUNCE_CYCLES(DC),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clkrst_core_clk  (clk),
        .clkrst_core_rst_n(rst_n),
        .raw_switches     (raw_switches),
        .raw_buttons      (raw_buttons),
        .mmio             (mmio)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic row(input logic [9:0] sw, input logic [3:0] btn, input logic [3:0] clr,
                       input logic [9:0] e_sw, input logic [3:0] e_btn, input logic [3:0] e_press,
                       input logic e_chg, input logic [3:0] e_sticky, input int reps);
        vec_t v;
        v = '{sw, btn, clr, e_sw, e_btn, e_press, e_chg, e_sticky};
        for (int k = 0; k < reps; k++) tbl.push_back(v);
    endtask

    initial begin
        int rise_cycle;
        int chg_count;
        logic [3:0] press_seen;
        logic [3:0] btn_seen;

        mmio.press_clear = '0;

        // Clean press, sticky set/clear race, release without pulse
        row(10'h000, 4'hF, 4'h0, 10'h000, 4'h0, 4'h0, 1'b0, 4'h0, 1);
        row(10'h000, 4'hE, 4'h0, 10'h000, 4'h0, 4'h0, 1'b0, 4'h0, 5);
        row(10'h000, 4'hE, 4'h0, 10'h000, 4'h1, 4'h1, 1'b0, 4'h1, 1);
        row(10'h000, 4'hE, 4'h1, 10'h000, 4'h1, 4'h0, 1'b0, 4'h1, 1);
        row(10'h000, 4'hE, 4'h1, 10'h000, 4'h1, 4'h0, 1'b0, 4'h0, 1);
        row(10'h000, 4'hF, 4'h0, 10'h000, 4'h1, 4'h0, 1'b0, 4'h0, 5);
        row(10'h000, 4'hF, 4'h0, 10'h000, 4'h0, 4'h0, 1'b0, 4'h0, 1);
        // Bouncing switch 3: high 2, low 1, then held high
        row(10'h008, 4'hF, 4'h0, 10'h000, 4'h0, 4'h0, 1'b0, 4'h0, 2);
        row(10'h000, 4'hF, 4'h0, 10'h000, 4'h0, 4'h0, 1'b0, 4'h0, 1);
        row(10'h008, 4'hF, 4'h0, 10'h000, 4'h0, 4'h0, 1'b0, 4'h0, 5);
        row(10'h008, 4'hF, 4'h0, 10'h008, 4'h0, 4'h0, 1'b1, 4'h0, 1);
        row(10'h008, 4'hF, 4'h0, 10'h008, 4'h0, 4'h0, 1'b0, 4'h0, 1);
        // Three-cycle glitch on button 2 must be rejected
        row(10'h008, 4'hB, 4'h0, 10'h008, 4'h0, 4'h0, 1'b0, 4'h0, 3);
        row(10'h008, 4'hF, 4'h0, 10'h008, 4'h0, 4'h0, 1'b0, 4'h0, 5);
        // All switches high together: one update, one pulse
        row(10'h3FF, 4'hF, 4'h0, 10'h008, 4'h0, 4'h0, 1'b0, 4'h0, 5);
        row(10'h3FF, 4'hF, 4'h0, 10'h3FF, 4'h0, 4'h0, 1'b1, 4'h0, 1);
        row(10'h3FF, 4'hF, 4'h0, 10'h3FF, 4'h0, 4'h0, 1'b0, 4'h0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ext_switches", 32'(mmio.ext_switches), 32'h0);
        check("rst_ext_buttons",  32'(mmio.ext_buttons),  32'h0);
        check("rst_btn_press",    32'(mmio.btn_press),    32'h0);
        check("rst_sw_change",    32'(mmio.sw_change),    32'h0);
        check("rst_press_sticky", 32'(mmio.press_sticky), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            raw_switches     = tbl[i].sw;
            raw_buttons      = tbl[i].btn;
            mmio.press_clear = tbl[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ext_switches", i), 32'(mmio.ext_switches), 32'(tbl[i].e_sw));
            check($sformatf("v%0d_ext_buttons", i),  32'(mmio.ext_buttons),  32'(tbl[i].e_btn));
            check($sformatf("v%0d_btn_press", i),    32'(mmio.btn_press),    32'(tbl[i].e_press));
            check($sformatf("v%0d_sw_change", i),    32'(mmio.sw_change),    32'(tbl[i].e_chg));
            check($sformatf("v%0d_press_sticky", i), 32'(mmio.press_sticky), 32'(tbl[i].e_sticky));
        end

        // Reset three cycles into a button 1 debounce
        @(negedge clk);
        mmio.press_clear = '0;
        raw_buttons = 4'hD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ext_switches", 32'(mmio.ext_switches), 32'h0);
        check("midrst_ext_buttons",  32'(mmio.ext_buttons),  32'h0);
        check("midrst_btn_press",    32'(mmio.btn_press),    32'h0);
        check("midrst_sw_change",    32'(mmio.sw_change),    32'h0);
        check("midrst_press_sticky", 32'(mmio.press_sticky), 32'h0);

        // Release with buttons idle and switch 0 high
        raw_buttons  = 4'hF;
        raw_switches = 10'h001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rise_cycle = 0;
        chg_count  = 0;
        press_seen = '0;
        btn_seen   = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (rise_cycle == 0 && mmio.ext_switches[0]) rise_cycle = k;
            chg_count  += int'(mmio.sw_change);
            press_seen |= mmio.btn_press;
            btn_seen   |= mmio.ext_buttons;
        end
        check("rel_sw0_rise_cycle", 32'(rise_cycle), 32'(DC + 2));
        check("rel_sw_change_count", 32'(chg_count), 32'd1);
        check("rel_ext_switches", 32'(mmio.ext_switches), 32'h001);
        check("rel_no_btn_press", 32'(press_seen), 32'h0);
        check("rel_no_ext_buttons", 32'(btn_seen), 32'h0);
        check("rel_press_sticky", 32'(mmio.press_sticky), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mcpu_soc_swdebounce.md
MCPU_SOC_SWDEBOUNCE -- requirements
Module: mcpu_soc_swdebounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required before an input change is accepted (valid range 2..65535).
REQ-002 SHALL have parameter BTN_ACTIVE_LOW, default 1, meaning raw buttons read 0 when pressed and are inverted at the input.
REQ-003 SHALL have input clkrst_core_clk, 1 bit, the single core clock; all logic on its rising edge.
REQ-004 SHALL have input clkrst_core_rst_n, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have input raw_switches, 10 bits, asynchronous board switch pins.
REQ-006 SHALL have input raw_buttons, 4 bits, asynchronous board button pins.
REQ-007 SHALL have input press_clear, 4 bits, one-cycle write-1-to-clear strobe for press_sticky bits.
REQ-008 SHALL have output ext_switches, 10 bits, debounced switch levels feeding the LED/switch MMIO block.
REQ-009 SHALL have output ext_buttons, 4 bits, debounced button levels, 1 = pressed.
REQ-010 SHALL have output btn_press, 4 bits, one-cycle pulse per button on debounced press (0->1).
REQ-011 SHALL have output sw_change, 1 bit, one-cycle pulse when any debounced switch changes.
REQ-012 SHALL have output press_sticky, 4 bits, per-button latched press flag.

Function
REQ-013 SHALL pass each of the 14 raw inputs (buttons after optional inversion) through a two-flop synchronizer before any other use.
REQ-014 SHALL keep one 16-bit counter and one stable bit per input channel.
REQ-015 SHALL clear a channel's counter on any cycle where synchronized value equals its stable bit.
REQ-016 SHALL increment the counter each cycle synchronized value differs from stable bit and counter < DEBOUNCE_CYCLES-1.
REQ-017 SHALL, when counter == DEBOUNCE_CYCLES-1 and mismatch persists, load the stable bit with the synchronized value and clear the counter on the same edge.
REQ-018 SHALL therefore update ext_switches/ext_buttons exactly DEBOUNCE_CYCLES+2 cycles after a clean raw transition settles before a clock edge.
REQ-019 SHALL reject any synchronized pulse or glitch shorter than DEBOUNCE_CYCLES cycles (counter restarts from 0 on every return to the stable value).
REQ-020 SHALL assert btn_press[i] (registered) for exactly the one cycle in which ext_buttons[i] first reads 1; no pulse on release.
REQ-021 SHALL assert sw_change (registered) for exactly the one cycle in which any ext_switches bit first shows a new value; simultaneous switch changes give one pulse.
REQ-022 SHALL set press_sticky[i] on the edge btn_press[i] is asserted and clear it on the edge after press_clear[i]=1; if set and clear coincide, set wins.
REQ-023 SHALL debounce all 14 channels independently; simultaneous events on several channels SHALL not interact.
REQ-024 SHALL never wrap a counter; it saturates at DEBOUNCE_CYCLES-1 at most.

Reset
REQ-025 SHALL, on clkrst_core_rst_n low, asynchronously force synchronizer flops, stable bits, counters, btn_press, sw_change and press_sticky to 0.
REQ-026 SHALL, after reset release with a switch raw high, raise that ext_switches bit DEBOUNCE_CYCLES+2 cycles later and pulse sw_change once.
REQ-027 SHALL abandon any in-progress debounce on reset assertion mid-count; no pulse generated for it.

Structure
REQ-028 SHALL define per-channel logic (2-flop sync, counter, stable bit) as sub-module mcpu_soc_debounce_chan, instantiated 14 times.
REQ-029 SHALL place channel counts (NUM_SW=10, NUM_BTN=4) and counter width (16) in the shared SoC package; DEBOUNCE_CYCLES stays a module parameter.

Verification (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
REQ-030 Clean press: raw_buttons 4'hF->4'hE held -> ext_buttons[0]=1 six cycles later, btn_press=4'h1 for one cycle, press_sticky=4'h1.
REQ-031 Bounce: raw_switches[3] toggles high 2 cycles, low 1, high held -> ext_switches[3] rises 6 cycles after final rise; exactly one sw_change pulse.
REQ-032 Glitch: raw_buttons[2] low for 3 cycles then high -> ext_buttons stays 0, no btn_press.
REQ-033 Sticky: press_clear=4'h1 on the same cycle as btn_press[0] -> press_sticky[0] stays 1; clear next cycle -> 0.
REQ-034 Simultaneous: raw_switches 10'h000->10'h3FF -> ext_switches=10'h3FF in one cycle, single sw_change pulse.
REQ-035 Reset mid-count: assert clkrst_core_rst_n low 3 cycles into a button debounce -> all outputs 0 immediately; no btn_press after release while raw released.
